// File: rtl/soc_spi_sram_pkg.sv
// Shared opcodes, frame geometry and FSM state type for the SPI SRAM bridge.
package soc_spi_sram_pkg;

    localparam logic [7:0]  OP_READ    = 8'h03;
    localparam logic [7:0]  OP_WRITE   = 8'h02;
    localparam int unsigned BITS_TOTAL = 64;
    localparam int unsigned DATA_START = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Reorders a little-endian word so an MSB-first shift emits byte0 first.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/soc_spi_sram_ctrl.sv
// Word-wide memory port to SPI SRAM bridge: one 64-bit READ/WRITE frame per request,
// mode 0 SCK at half the system clock, single-cycle ack when the frame ends.
module soc_spi_sram_ctrl
    import soc_spi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_data_write,
    input  logic        sram_we,
    input  logic        sram_cs,
    output logic [31:0] sram_data_read,
    output logic        sram_ack,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [5:0] LAST_BIT   = 6'(BITS_TOTAL - 1);
    localparam logic [5:0] FIRST_DATA = 6'(DATA_START);

    state_e      state_q, state_d;
    logic [63:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        ack_q, ack_d;
    logic [23:0] byte_addr;
    logic        bit_end;
    logic        unused_addr_hi;

    // Word address bits above the SRAM byte range are intentionally dropped.
    assign unused_addr_hi = ^sram_addr[31:ADDR_W-2];

    always_comb begin
        byte_addr = '0;
        byte_addr[ADDR_W-1:0] = {sram_addr[ADDR_W-3:0], 2'b00};
    end

    // Last cycle of an SCK-high phase: MISO is sampled and MOSI advances here.
    assign bit_end = (state_q == ST_SHIFT) && sck_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sram_cs) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_end && (cnt_q == LAST_BIT)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sck_d   = 1'b0;
        cs_n_d  = 1'b1;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sram_cs) begin
                    tx_d   = {sram_we ? OP_WRITE : OP_READ, byte_addr,
                              sram_we ? byte_swap(sram_data_write) : 32'h0};
                    we_d   = sram_we;
                    cnt_d  = '0;
                    cs_n_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                cs_n_d = 1'b0;
                sck_d  = ~sck_q;
                if (bit_end) begin
                    tx_d  = {tx_q[62:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q >= FIRST_DATA) rx_d = {rx_q[30:0], spi_miso};
                    if (cnt_q == LAST_BIT) begin
                        cs_n_d = 1'b1;
                        ack_d  = 1'b1;
                        if (!we_q) rdata_d = byte_swap({rx_q[30:0], spi_miso});
                    end
                end
            end
            default: ;
        endcase
    end

    assign spi_sck        = sck_q;
    assign spi_cs_n       = cs_n_q;
    assign spi_mosi       = tx_q[63];
    assign sram_ack       = ack_q;
    assign sram_data_read = rdata_q;

endmodule

// File: tb/tb_soc_spi_sram_ctrl.sv
// Bench for soc_spi_sram_ctrl: behavioural SPI SRAM slave plus a byte-level reference memory.
module tb_soc_spi_sram_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_data_write = '0;
    logic        sram_we = 1'b0;
    logic        sram_cs = 1'b0;
    logic [31:0] sram_data_read;
    logic        sram_ack;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_spi_sram_ctrl #(.ADDR_W(17)) dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .sram_addr       (sram_addr),
        .sram_data_write (sram_data_write),
        .sram_we         (sram_we),
        .sram_cs         (sram_cs),
        .sram_data_read  (sram_data_read),
        .sram_ack        (sram_ack),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    // External SPI SRAM model: samples MOSI while SCK is high, drives MISO in the low phase.
    logic [7:0]  sram_mem [int];
    logic [63:0] sh = '0;
    logic [63:0] last_stream = '0;
    logic [7:0]  s_cmd = '0;
    logic [23:0] s_addr = '0;
    logic [7:0]  tb_byte;
    logic        mosi_low = 1'b0;
    int          bitn = 0;
    int          done_cnt = 0;
    int          mosi_glitch = 0;

    function automatic logic [7:0] sram_rd(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return init_byte(a);
    endfunction

    always @(negedge clk) begin
        if (spi_cs_n) begin
            bitn = 0;
        end else if (spi_sck) begin
            if (spi_mosi !== mosi_low) mosi_glitch++;
            sh = {sh[62:0], spi_mosi};
            bitn++;
            if (bitn == 32) begin
                s_cmd  = sh[31:24];
                s_addr = sh[23:0];
            end
            if (bitn == 64) begin
                last_stream = sh;
                done_cnt++;
                if (s_cmd == 8'h02)
                    for (int j = 0; j < 4; j++) sram_mem[int'(s_addr) + j] = sh[31 - 8*j -: 8];
            end
        end else begin
            mosi_low = spi_mosi;
            if (bitn >= 32 && s_cmd == 8'h03) begin
                tb_byte  = sram_rd(int'(s_addr) + (bitn - 32) / 8);
                spi_miso = tb_byte[7 - ((bitn - 32) % 8)];
            end else begin
                spi_miso = 1'b0;
            end
        end
    end

    // Reference: what the CPU should see, tracked per byte address.
    logic [7:0]  ref_mem [int];
    logic [31:0] last_rd_exp = '0;
    logic [63:0] got_stream;
    logic [31:0] got_rd;

    function automatic logic [7:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of cycle T0+130.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int drop_at, input bit b2b,
                           input logic nwe, input logic [31:0] naddr, input logic [31:0] nwd);
        int          ba, pulses, ack_at, csn_bad, seq0;
        logic        prev_sck;
        logic [31:0] dbytes, exp_rd;
        logic [63:0] exp_stream;
        ba     = int'((addr * 32'd4) % 32'h0002_0000);
        dbytes = '0;
        exp_rd = last_rd_exp;
        for (int b = 0; b < 4; b++) begin
            if (we) dbytes = {dbytes[23:0], wd[8*b +: 8]};
            else    exp_rd[8*b +: 8] = ref_rd(ba + b);
        end
        exp_stream = {(we ? 8'h02 : 8'h03), 24'(ba), dbytes};

        sram_cs = 1'b1; sram_we = we; sram_addr = addr; sram_data_write = wd;
        seq0 = done_cnt; pulses = 0; ack_at = -1; csn_bad = 0; prev_sck = 1'b0;
        got_rd = '0;
        for (int n = 1; n <= 140 && ack_at < 0; n++) begin
            @(negedge clk);
            if (spi_sck && !prev_sck) pulses++;
            prev_sck = spi_sck;
            if (sram_ack) begin
                ack_at = n;
                got_rd = sram_data_read;
                chk("ack_cs_n_high", 64'(spi_cs_n), 64'd1);
            end else if (spi_cs_n) begin
                csn_bad++;
            end
            if (n == drop_at) begin
                sram_cs = 1'b0; sram_we = ~we;
                sram_addr = $urandom(); sram_data_write = $urandom();
            end
        end
        got_stream = last_stream;
        chk("ack_latency", 64'(ack_at), 64'd129);
        chk("sck_pulses", 64'(pulses), 64'd64);
        chk("cs_n_low_window", 64'(csn_bad), 64'd0);
        chk("frame_count", 64'(done_cnt - seq0), 64'd1);
        chk("mosi_stream", got_stream, exp_stream);
        chk("rdata_at_ack", 64'(got_rd), 64'(exp_rd));

        if (we) for (int b = 0; b < 4; b++) ref_mem[ba + b] = wd[8*b +: 8];
        else    last_rd_exp = exp_rd;

        if (b2b) begin
            sram_we = nwe; sram_addr = naddr; sram_data_write = nwd;
        end else begin
            sram_cs = 1'b0;
        end
        @(negedge clk);
        chk("ack_single_cycle", 64'(sram_ack), 64'd0);
        chk("cs_n_gap", 64'(spi_cs_n), 64'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [63:0] exp_stream;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] ra;
    int          bad;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hDDCC_BBAA, 64'h02_000010_AABBCCDD, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         64'h03_000010_00000000, 32'hDDCC_BBAA};
        vecs[2] = '{1'b1, 32'h0001_FFFF, 32'h1122_3344, 64'h02_01FFFC_44332211, 32'h0};
        vecs[3] = '{1'b1, 32'h0002_0000, 32'h5566_7788, 64'h02_000000_88776655, 32'h0};
        vecs[4] = '{1'b0, 32'h0001_FFFF, 32'h0,         64'h03_01FFFC_00000000, 32'h1122_3344};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         64'h03_000000_00000000, 32'h5566_7788};

        // Reset held with a pending request: the SPI bus must stay quiet.
        #1 i_rst_n = 1'b0;
        sram_cs = 1'b1; sram_we = 1'b0; sram_addr = 32'h100;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (spi_sck || !spi_cs_n || sram_ack) bad++;
        end
        chk("reset_hold_quiet", 64'(bad), 64'd0);
        chk("reset_rdata", 64'(sram_data_read), 64'd0);
        i_rst_n = 1'b1;
        run_txn(1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, 0, 1'b0, 1'b0, '0, '0);
            chk("vec_stream", got_stream, vecs[i].exp_stream);
            if (!vecs[i].we) chk("vec_rdata", 64'(got_rd), 64'(vecs[i].exp_rd));
        end

        // Request dropped mid-frame still completes.
        run_txn(1'b1, 32'h30, 32'h0BAD_BEEF, 40, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 32'h30, 32'h0, 0, 1'b0, 1'b0, '0, '0);
        chk("drop_readback", 64'(got_rd), 64'h0BAD_BEEF);

        // Back-to-back: next capture lands at T0+130.
        run_txn(1'b1, 32'h20, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h20, 32'h0);
        run_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0, '0, '0);
        chk("b2b_readback", 64'(got_rd), 64'hCAFE_F00D);

        // Asynchronous reset in the middle of a write frame.
        sram_cs = 1'b1; sram_we = 1'b1; sram_addr = 32'h8; sram_data_write = 32'h1234_5678;
        repeat (50) @(negedge clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
        chk("abort_sck", 64'(spi_sck), 64'd0);
        chk("abort_ack", 64'(sram_ack), 64'd0);
        sram_cs = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        last_rd_exp = '0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (sram_ack || !spi_cs_n) bad++;
        end
        chk("abort_idle", 64'(bad), 64'd0);
        run_txn(1'b0, 32'h8, 32'h0, 0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 30; i++) begin
            ra = ($urandom() & 32'hFFFE_0000) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = ra | 32'h0001_FFF0;
            run_txn($urandom_range(0, 1) == 1, ra, $urandom(), 0, 1'b0, 1'b0, '0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("mosi_stable_while_high", 64'(mosi_glitch), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
